alu_share_ctrl: RTL
===================

// Module: alu_share_ctrl
// PURPOSE
//  Arbitrates and sequences two requesters onto the single shared alu (add/sub/mul/div).
//  Picks one requester round-robin and latches its operands and opcode.
//  Holds the alu inputs stable for an op-dependent number of cycles (multicycle mul/div paths).
//  Returns the captured result with a valid/ready response handshake.
// PARAMETERS
//  WIDTH       32  operand/result width; matches alu input1/input2/result
//  MUL_CYCLES  2   cycles alu inputs are held for op MUL (>=1)
//  DIV_CYCLES  4   cycles alu inputs are held for op DIV (>=1)
// PORTS
//  clk                input   1      rising-edge clock
//  reset              input   1      synchronous, active-high reset
//  req0_valid         input   1      requester 0 has an op pending
//  req0_ready         output  1      requester 0 op accepted this cycle
//  req0_op            input   8      opcode: 0=ADD 1=SUB 2=MUL 3=DIV; others illegal
//  req0_input1        input   WIDTH  operand A
//  req0_input2        input   WIDTH  operand B
//  req1_valid/req1_ready/req1_op/req1_input1/req1_input2: same as requester 0, for requester 1
//  alu_input1         output  WIDTH  to alu input1
//  alu_input2         output  WIDTH  to alu input2
//  alu_controlresult  output  8      to alu controlresult
//  alu_result         input   WIDTH  from alu result
//  rsp_valid          output  1      response available
//  rsp_ready          input   1      consumer takes response
//  rsp_id             output  1      requester that issued the op
//  rsp_result         output  WIDTH  captured result; 0 on error
//  rsp_err            output  1      illegal opcode, or DIV with operand B == 0
// BEHAVIOUR
//  Reset
//   - State=IDLE; rr_ptr=0 (req0 favoured).
//   - req*_ready, rsp_valid, rsp_id, rsp_err = 0.
//   - rsp_result, alu_input1/2, alu_controlresult = 0.
//   - A reset mid-operation abandons the op. No response is produced for it.
//  FSM: IDLE -> EXEC -> RESP -> IDLE
//  IDLE
//   - Grant: if exactly one valid, grant it. If both valid, grant rr_ptr.
//   - reqN_ready = (state==IDLE) & grantN. Combinational; at most one ready per cycle.
//   - On accept: latch op/operands/id; set rr_ptr = ~id.
//   - Legal op, and not DIV-by-zero: load cnt = L-1 and go to EXEC.
//     L is 1 for ADD/SUB, MUL_CYCLES for MUL, DIV_CYCLES for DIV.
//   - Illegal op, or DIV with B==0: skip EXEC and go to RESP with rsp_err=1, rsp_result=0.
//   - Idle alu outputs are driven 0.
//  EXEC
//   - alu_input1/2/controlresult are driven from the latched values, stable for L cycles.
//   - cnt decrements each cycle.
//   - When cnt==0: capture alu_result into rsp_result, set rsp_err=0, go to RESP.
//  RESP
//   - rsp_valid=1. rsp_id/result/err are held stable until rsp_valid & rsp_ready.
//   - On that handshake cycle go to IDLE; rsp_valid drops the next cycle.
//   - No new op is accepted while in EXEC or RESP.
//  Timing
//   - Accept in cycle T -> rsp_valid first high in cycle T+L+1.
//   - Error path: rsp_valid high in T+1.
//  Throughput and width
//   - Best-case initiation interval is L+2 cycles: one op in flight; the returning IDLE cycle can accept.
//   - No width extension: results truncate to WIDTH, exactly as the alu produces them.
//   - Operands are latched, so requesters may change inputs after their ready cycle.
// TESTING
//  1. Reset, req0 ADD 5+7 alone
//     -> req0_ready in cycle T; rsp_valid at T+2 with id=0, result=12, err=0.
//  2. Both valid from reset: req0 SUB 10-3, req1 MUL 6*7 (MUL_CYCLES=2), rsp_ready=1
//     -> req0 served first (result 7).
//     -> req1 served next: alu inputs held 2 cycles, result 42, id=1.
//  3. req1 DIV 100/0 -> err=1, result=0, rsp_valid at T+1; alu_controlresult never shows 3.
//     Then req1 op=8'h09 -> err=1, result=0.
//  4. rsp_ready=0 for 5 cycles during RESP
//     -> response held stable; both readys stay 0; exactly one handshake when rsp_ready rises.
//  5. Assert reset during EXEC of a DIV -> next cycle IDLE, all outputs 0, no response.
//     Then a fresh req0 ADD completes normally.
//  6. Both requesters continuously valid for 6 ops -> grants alternate 0,1,0,1,0,1.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// ============================================================================
// alu_share_ctrl : round-robin sequencer of two requesters onto one shared ALU
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_share_ctrl #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [7:0]       req0_op,
  input  logic [WIDTH-1:0] req0_input1,
  input  logic [WIDTH-1:0] req0_input2,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [7:0]       req1_op,
  input  logic [WIDTH-1:0] req1_input1,
  input  logic [WIDTH-1:0] req1_input2,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [7:0]       alu_controlresult,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err
);

  localparam int MAX_L = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_L + 1);
  localparam logic [7:0] OP_MUL = 8'd2;
  localparam logic [7:0] OP_DIV = 8'd3;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             id_q, id_d;
  logic [7:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;

  logic             grant0, grant1;
  logic [7:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;

  // rr_ptr only breaks ties; a lone requester is always granted
  assign grant0 = req0_valid & (~req1_valid | ~rr_ptr_q);
  assign grant1 = req1_valid & (~req0_valid |  rr_ptr_q);
  assign sel_op = grant1 ? req1_op     : req0_op;
  assign sel_a  = grant1 ? req1_input1 : req0_input1;
  assign sel_b  = grant1 ? req1_input2 : req0_input2;

  assign req0_ready        = (state_q == IDLE) & grant0;
  assign req1_ready        = (state_q == IDLE) & grant1;
  assign alu_input1        = (state_q == EXEC) ? a_q  : '0;
  assign alu_input2        = (state_q == EXEC) ? b_q  : '0;
  assign alu_controlresult = (state_q == EXEC) ? op_q : 8'd0;
  assign rsp_valid         = (state_q == RESP);
  assign rsp_id            = id_q;
  assign rsp_result        = result_q;
  assign rsp_err           = err_q;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (grant0 | grant1) begin
          id_d     = grant1;
          rr_ptr_d = ~grant1;
          op_d     = sel_op;
          a_d      = sel_a;
          b_d      = sel_b;
          // Illegal ops and divide-by-zero never reach the ALU
          if ((sel_op > OP_DIV) || ((sel_op == OP_DIV) && (sel_b == '0))) begin
            result_d = '0;
            err_d    = 1'b1;
            state_d  = RESP;
          end else begin
            if (sel_op == OP_MUL)      cnt_d = MUL_LAST;
            else if (sel_op == OP_DIV) cnt_d = DIV_LAST;
            else                       cnt_d = '0;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          result_d = alu_result;
          err_d    = 1'b0;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b0;
      id_q     <= 1'b0;
      op_q     <= 8'd0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

endmodule

`default_nettype wire
